// File: rtl/serial_tx_fifo.sv
//==============================================================================
// Module  : serial_tx_fifo
// Brief   : UART transmitter with configurable frame format and input FIFO.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_tx_fifo #(
    parameter int CLKS_PER_BIT = 417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_data_available,
    output logic                          tx_ready,
    input  logic                          tx_enable,
    output logic                          serial_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_TMR_W  = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_ADDR_W:0]    c_FULL      = (c_ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_TMR_W-1:0]   c_LAST_TICK = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]   c_LAST_DATA = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0]   c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]  r_wr_ptr;
    logic [c_ADDR_W-1:0]  r_rd_ptr;
    logic [c_ADDR_W:0]    r_count;

    state_t               r_state;
    logic [c_TMR_W-1:0]   r_timer;
    logic [c_BIT_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_serial;

    state_t               w_state_next;
    logic [c_TMR_W-1:0]   w_timer_next;
    logic [c_BIT_W-1:0]   w_bit_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_par_next;
    logic                 w_serial_next;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_can_start;
    logic [DATA_BITS-1:0] w_head;

    assign tx_ready    = !reset && (r_count != c_FULL);
    assign w_push      = tx_data_available && tx_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_bit_end   = (r_timer == c_LAST_TICK);
    assign w_can_start = (r_count != '0) && tx_enable;

    assign serial_tx  = r_serial;
    assign busy       = (r_state != S_IDLE);
    assign fifo_count = r_count;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_serial  <= 1'b1;
        end else begin
            r_timer   <= w_timer_next;
            r_bit_idx <= w_bit_next;
            r_shift   <= w_shift_next;
            r_par_bit <= w_par_next;
            r_serial  <= w_serial_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = w_bit_end ? '0 : r_timer + 1'b1;
        w_bit_next    = r_bit_idx;
        w_shift_next  = r_shift;
        w_par_next    = r_par_bit;
        w_serial_next = r_serial;
        w_pop         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_timer_next  = '0;
                w_serial_next = 1'b1;
                if (w_can_start) begin
                    w_pop         = 1'b1;
                    w_shift_next  = w_head;
                    w_par_next    = (PARITY == 1) ? ~(^w_head) : (^w_head);
                    w_bit_next    = '0;
                    w_serial_next = 1'b0;
                    w_state_next  = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bit_next    = '0;
                    w_serial_next = r_shift[0];
                    w_state_next  = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == c_LAST_DATA) begin
                        w_bit_next = '0;
                        if (PARITY != 0) begin
                            w_serial_next = r_par_bit;
                            w_state_next  = S_PARITY;
                        end else begin
                            w_serial_next = 1'b1;
                            w_state_next  = S_STOP;
                        end
                    end else begin
                        w_bit_next    = r_bit_idx + 1'b1;
                        w_shift_next  = r_shift >> 1;
                        w_serial_next = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_bit_next    = '0;
                    w_serial_next = 1'b1;
                    w_state_next  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_idx == c_LAST_STOP) begin
                        // Chain straight into the next start bit when more data is waiting.
                        if (w_can_start) begin
                            w_pop         = 1'b1;
                            w_shift_next  = w_head;
                            w_par_next    = (PARITY == 1) ? ~(^w_head) : (^w_head);
                            w_bit_next    = '0;
                            w_serial_next = 1'b0;
                            w_state_next  = S_START;
                        end else begin
                            w_serial_next = 1'b1;
                            w_state_next  = S_IDLE;
                        end
                    end else begin
                        w_bit_next = r_bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_serial_next = 1'b1;
                w_state_next  = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_tx_fifo.sv
//==============================================================================
// Module  : tb_serial_tx_fifo
// Brief   : Directed self-checking bench for serial_tx_fifo (8N1, 8E1, 8O2).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_tx_fifo;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       av;
    logic       en;
    int         sel;

    int checks = 0;
    int errors = 0;

    logic av_a, av_b, av_c, en_a, en_b, en_c;
    logic a_ready, a_serial, a_busy;
    logic b_ready, b_serial, b_busy;
    logic c_ready, c_serial, c_busy;
    logic [2:0] a_count, b_count, c_count;
    logic m_ready, m_serial, m_busy;
    logic [2:0] m_count;

    always #5 clk = ~clk;

    always_comb begin
        av_a = av && (sel == 0);
        av_b = av && (sel == 1);
        av_c = av && (sel == 2);
        en_a = en && (sel == 0);
        en_b = en && (sel == 1);
        en_c = en && (sel == 2);
        case (sel)
            1: begin
                m_ready = b_ready; m_serial = b_serial; m_busy = b_busy; m_count = b_count;
            end
            2: begin
                m_ready = c_ready; m_serial = c_serial; m_busy = c_busy; m_count = c_count;
            end
            default: begin
                m_ready = a_ready; m_serial = a_serial; m_busy = a_busy; m_count = a_count;
            end
        endcase
    end

    serial_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clock(clk), .reset(rst), .tx_data(data), .tx_data_available(av_a), .tx_ready(a_ready),
        .tx_enable(en_a), .serial_tx(a_serial), .busy(a_busy), .fifo_count(a_count)
    );

    serial_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .clock(clk), .reset(rst), .tx_data(data), .tx_data_available(av_b), .tx_ready(b_ready),
        .tx_enable(en_b), .serial_tx(b_serial), .busy(b_busy), .fifo_count(b_count)
    );

    serial_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .clock(clk), .reset(rst), .tx_data(data), .tx_data_available(av_c), .tx_ready(c_ready),
        .tx_enable(en_c), .serial_tx(c_serial), .busy(c_busy), .fifo_count(c_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Captures nbits bit-times; bits[0] is the start bit, each bit held CPB cycles.
    task automatic check_frame(input string name, input logic [11:0] bits, input int nbits,
                               input bit expect_idle);
        logic [47:0] obs;
        logic [47:0] exp;
        bit          busy_ok;
        obs     = '0;
        exp     = '0;
        busy_ok = 1'b1;
        for (int k = 0; k < nbits * CPB; k++) begin
            tick();
            obs[k] = m_serial;
            exp[k] = bits[k / CPB];
            if (m_busy !== 1'b1) busy_ok = 1'b0;
        end
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s_line: got %h expected %h", name, obs, exp);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s_busy: busy dropped during frame, expected high throughout", name);
        end
        if (expect_idle) begin
            tick();
            checks++;
            if ({m_busy, m_serial} !== 2'b01) begin
                errors++;
                $display("FAIL %s_idle: busy,serial = %b expected 01", name, {m_busy, m_serial});
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        av   = 1'b0;
        en   = 1'b0;
        data = 8'h00;
        sel  = 0;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            checks++;
            if ({m_serial, m_busy, m_count, m_ready} !== 6'b1_0_000_0) begin
                errors++;
                $display("FAIL reset_state[%0d]: serial,busy,count,ready = %b expected 100000",
                         s, {m_serial, m_busy, m_count, m_ready});
            end
        end
        sel = 0;
        rst = 1'b0;
        tick();
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", m_ready);
        end
    endtask

    task automatic test_frame_8n1();
        sel  = 0;
        en   = 1'b1;
        data = 8'h55;
        av   = 1'b1;
        tick();
        av = 1'b0;
        checks++;
        if ({m_count, m_serial} !== 4'b001_1) begin
            errors++;
            $display("FAIL accept_55: count,serial = %b expected 0011", {m_count, m_serial});
        end
        check_frame("f8n1_55", 12'h2AA, 10, 1'b1);
        checks++;
        if (m_count !== 3'd0) begin
            errors++;
            $display("FAIL f8n1_count: got %0d expected 0", m_count);
        end
        en = 1'b0;
    endtask

    task automatic test_parity_even();
        sel  = 1;
        en   = 1'b1;
        data = 8'h07;
        av   = 1'b1;
        tick();
        av = 1'b0;
        check_frame("even_07", 12'h60E, 11, 1'b1);
        en = 1'b0;
    endtask

    task automatic test_stop2_odd_back_to_back();
        sel  = 2;
        en   = 1'b0;
        av   = 1'b1;
        data = 8'h07;
        tick();
        data = 8'h80;
        tick();
        av = 1'b0;
        repeat (3) tick();
        checks++;
        if ({m_count, m_busy, m_serial} !== 5'b010_0_1) begin
            errors++;
            $display("FAIL hold_disabled: count,busy,serial = %b expected 01001",
                     {m_count, m_busy, m_serial});
        end
        en = 1'b1;
        check_frame("odd2_07", 12'hC0E, 12, 1'b0);
        check_frame("odd2_80", 12'hD00, 12, 1'b1);
        en = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [9:0]  frm [5];
        logic [39:0] obs [5];
        logic [39:0] exp;
        bit          was;
        bit          busy_ok;
        int          acc;
        frm = '{10'h282, 10'h284, 10'h286, 10'h288, 10'h28A};
        sel  = 0;
        en   = 1'b0;
        av   = 1'b1;
        data = 8'h41;
        acc  = 0;
        for (int i = 0; i < 8; i++) begin
            was = m_ready;
            tick();
            if (was) begin
                acc++;
                data = data + 8'h01;
            end
        end
        checks++;
        if (acc !== 4) begin
            errors++;
            $display("FAIL full_accepts: got %0d expected 4", acc);
        end
        checks++;
        if ({m_count, m_ready, m_busy} !== 5'b100_0_0) begin
            errors++;
            $display("FAIL full_state: count,ready,busy = %b expected 10000", {m_count, m_ready, m_busy});
        end
        en      = 1'b1;
        busy_ok = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            obs[k / 40][k % 40] = m_serial;
            if (m_busy !== 1'b1) busy_ok = 1'b0;
            if (k == 0) begin
                checks++;
                if ({m_ready, m_count} !== 4'b1_011) begin
                    errors++;
                    $display("FAIL ready_after_pop: ready,count = %b expected 1011", {m_ready, m_count});
                end
            end
            if (k == 1) begin
                av = 1'b0;
                checks++;
                if (m_count !== 3'd4) begin
                    errors++;
                    $display("FAIL accept_45: count got %0d expected 4", m_count);
                end
            end
        end
        for (int f = 0; f < 5; f++) begin
            for (int j = 0; j < 40; j++) exp[j] = frm[f][j / CPB];
            checks++;
            if (obs[f] !== exp) begin
                errors++;
                $display("FAIL full_frame[%0d]: got %h expected %h", f, obs[f], exp);
            end
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL full_no_gap: busy dropped between queued frames, expected continuous");
        end
        tick();
        checks++;
        if ({m_busy, m_serial, m_count} !== 5'b0_1_000) begin
            errors++;
            $display("FAIL full_drained: busy,serial,count = %b expected 01000", {m_busy, m_serial, m_count});
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_order();
        logic [7:0]  d [10];
        logic [39:0] obs [10];
        logic [39:0] exp;
        logic [9:0]  fv;
        bit          was;
        int          idx;
        d = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h12, 8'hED, 8'h00, 8'hFF};
        sel  = 0;
        en   = 1'b1;
        data = d[0];
        av   = 1'b1;
        tick();
        idx  = 1;
        data = d[1];
        for (int k = 0; k < 400; k++) begin
            was = m_ready && av;
            tick();
            if (was) begin
                idx++;
                if (idx < 10) data = d[idx];
                else av = 1'b0;
            end
            obs[k / 40][k % 40] = m_serial;
            if (k == 0) begin
                checks++;
                if (m_count !== 3'd1) begin
                    errors++;
                    $display("FAIL push_pop_count: got %0d expected 1", m_count);
                end
            end
        end
        for (int f = 0; f < 10; f++) begin
            fv = {1'b1, d[f], 1'b0};
            for (int j = 0; j < 40; j++) exp[j] = fv[j / CPB];
            checks++;
            if (obs[f] !== exp) begin
                errors++;
                $display("FAIL wrap_frame[%0d]: got %h expected %h", f, obs[f], exp);
            end
        end
        tick();
        checks++;
        if ({m_busy, m_serial, m_count} !== 5'b0_1_000) begin
            errors++;
            $display("FAIL wrap_drained: busy,serial,count = %b expected 01000", {m_busy, m_serial, m_count});
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit quiet_ok;
        sel  = 0;
        en   = 1'b0;
        av   = 1'b1;
        data = 8'h11;
        repeat (4) begin
            tick();
            data = data + 8'h11;
        end
        av = 1'b0;
        en = 1'b1;
        repeat (11) tick();
        checks++;
        if ({m_busy, m_count, m_serial} !== 5'b1_011_0) begin
            errors++;
            $display("FAIL mid_frame: busy,count,serial = %b expected 10110", {m_busy, m_count, m_serial});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({m_serial, m_busy, m_count, m_ready} !== 6'b1_0_000_0) begin
            errors++;
            $display("FAIL reset_abort: serial,busy,count,ready = %b expected 100000",
                     {m_serial, m_busy, m_count, m_ready});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_release_ready: got %b expected 1", m_ready);
        end
        quiet_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if ({m_serial, m_busy, m_count} !== 5'b1_0_000) quiet_ok = 1'b0;
        end
        checks++;
        if (!quiet_ok) begin
            errors++;
            $display("FAIL abort_quiet: line activity after reset, expected idle and empty");
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_8n1();
        test_parity_even();
        test_stop2_odd_back_to_back();
        test_fifo_full();
        test_wrap_order();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
